l1a_check_sequencer: RTL and testbench

Parametrised L1A readout check sequencer for the LV2 layer-2 trigger path. Each accepted `need_check` request walks a one-hot `start_check` token across `NUM_ADC` ADC checker stages, advancing one stage per `adc_done` pulse. Up to `MAX_PENDING` requests may be queued. The block reports overflow, per-stage timeout and spurious-done errors as sticky flags that software can clear.

---
 rtl/l1a_check_pkg.sv | 15 +
 rtl/l1a_check_watchdog.sv | 40 ++++
 rtl/l1a_check_sequencer.sv | 115 +++++++++++
 tb/tb_l1a_check_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/l1a_check_pkg.sv
// Shared constants and types for the L1A check sequencer: error bit
// positions and the two-state sequencer enum.
package l1a_check_pkg;

   localparam int ERR_OVERFLOW = 0;
   localparam int ERR_TIMEOUT  = 1;
   localparam int ERR_SPURIOUS = 2;
   localparam int ERR_W        = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/l1a_check_watchdog.sv
// Per-stage watchdog: counts cycles while enabled and flags the cycle on
// which the count would reach TIMEOUT, then starts over from zero.
module l1a_check_watchdog
#(
   parameter int TIMEOUT = 4000
)
(
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   // Expiry clears the timer so a reloaded request gets a full window.
   always_comb begin
      expired = enable && !restart && (timer_q == LAST);
      timer_d = timer_q;
      if (restart || !enable || expired) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/l1a_check_sequencer.sv
// L1A readout check sequencer: walks a one-hot start_check token across the
// ADC stages for each queued request, with sticky overflow/timeout/spurious flags.
module l1a_check_sequencer
   import l1a_check_pkg::*;
#(
   parameter int NUM_ADC     = 16,
   parameter int MAX_PENDING = 4,
   parameter int TIMEOUT     = 4000
)
(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               need_check,
   input  logic                               adc_done,
   input  logic                               err_clear,
   output logic [NUM_ADC-1:0]                 start_check,
   output logic                               check_in_progress,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               check_done,
   output logic [ERR_W-1:0]                   error
);

   localparam int PW = $clog2(MAX_PENDING + 1);
   localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);
   localparam logic [NUM_ADC-1:0] FIRST = NUM_ADC'(1);

   state_e             state_q, state_d;
   logic [NUM_ADC-1:0] start_check_q, start_check_d;
   logic               in_progress_q, in_progress_d;
   logic [PW-1:0]      pending_q, pending_d;
   logic               check_done_q, check_done_d;
   logic [ERR_W-1:0]   error_q, error_d;

   logic               run;
   logic               accept;
   logic               complete;
   logic               abort;
   logic               finish;
   logic [ERR_W-1:0]   err_event;

   assign run = (state_q == RUN);

   l1a_check_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .restart (adc_done || !run),
      .enable  (run),
      .expired (abort)
   );

   always_comb begin
      accept   = need_check && (pending_q < PMAX);
      complete = run && adc_done && start_check_q[NUM_ADC-1];
      finish   = complete || abort;

      // A simultaneous accept and finish cancel out.
      pending_d = pending_q;
      if (accept && !finish) begin
         pending_d = pending_q + PW'(1);
      end else if (!accept && finish) begin
         pending_d = pending_q - PW'(1);
      end

      err_event               = '0;
      err_event[ERR_OVERFLOW] = need_check && !accept;
      err_event[ERR_TIMEOUT]  = abort;
      err_event[ERR_SPURIOUS] = !run && adc_done;

      state_d       = state_q;
      start_check_d = start_check_q;
      if (!run || finish) begin
         // Reload with no idle gap whenever work remains after this edge.
         if (pending_d != '0) begin
            state_d       = RUN;
            start_check_d = FIRST;
         end else begin
            state_d       = IDLE;
            start_check_d = '0;
         end
      end else if (adc_done) begin
         start_check_d = start_check_q << 1;
      end

      in_progress_d = (start_check_d != '0);
      check_done_d  = complete;
      error_d       = (err_clear ? '0 : error_q) | err_event;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         start_check_q <= '0;
         in_progress_q <= 1'b0;
         pending_q     <= '0;
         check_done_q  <= 1'b0;
         error_q       <= '0;
      end else begin
         state_q       <= state_d;
         start_check_q <= start_check_d;
         in_progress_q <= in_progress_d;
         pending_q     <= pending_d;
         check_done_q  <= check_done_d;
         error_q       <= error_d;
      end
   end

   assign start_check       = start_check_q;
   assign check_in_progress = in_progress_q;
   assign pending           = pending_q;
   assign check_done        = check_done_q;
   assign error             = error_q;

endmodule

// File: tb/tb_l1a_check_sequencer.sv
// Directed bench for l1a_check_sequencer (4 stages, 2 pending, timeout 10)
// with a per-cycle reference model and hand-computed literal checkpoints.
module tb_l1a_check_sequencer;

   localparam int N    = 4;
   localparam int MAXP = 2;
   localparam int TO   = 10;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         need_check = 1'b0;
   logic         adc_done = 1'b0;
   logic         err_clear = 1'b0;
   logic [N-1:0] start_check;
   logic         check_in_progress;
   logic [1:0]   pending;
   logic         check_done;
   logic [2:0]   error;

   int errors = 0;
   int checks = 0;
   bit armed  = 1'b0;

   // Reference model: stage index (-1 = idle), queue depth, cycles waited.
   int       m_stage = -1;
   int       m_cnt   = 0;
   int       m_wait  = 0;
   logic [2:0] m_err = 3'b000;
   logic     m_done  = 1'b0;

   l1a_check_sequencer #(
      .NUM_ADC     (N),
      .MAX_PENDING (MAXP),
      .TIMEOUT     (TO)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .need_check        (need_check),
      .adc_done          (adc_done),
      .err_clear         (err_clear),
      .start_check       (start_check),
      .check_in_progress (check_in_progress),
      .pending           (pending),
      .check_done        (check_done),
      .error             (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge clk) begin : model
      int ns, nc, nw;
      bit acc, fin, ab, sp, ov;
      if (reset) begin
         m_stage <= -1;
         m_cnt   <= 0;
         m_wait  <= 0;
         m_err   <= 3'b000;
         m_done  <= 1'b0;
      end else begin
         acc = need_check && (m_cnt < MAXP);
         ov  = need_check && !acc;
         fin = 1'b0; ab = 1'b0; sp = 1'b0;
         ns  = m_stage;
         nw  = m_wait;
         if (m_stage < 0) begin
            sp = adc_done;
         end else if (adc_done) begin
            if (m_stage == N - 1) fin = 1'b1;
            else begin
               ns = m_stage + 1;
               nw = 0;
            end
         end else if (m_wait + 1 == TO) begin
            ab = 1'b1;
         end else begin
            nw = m_wait + 1;
         end
         nc = m_cnt + (acc ? 1 : 0) - ((fin || ab) ? 1 : 0);
         if (fin || ab || m_stage < 0) begin
            ns = (nc > 0) ? 0 : -1;
            nw = 0;
         end
         m_stage <= ns;
         m_cnt   <= nc;
         m_wait  <= nw;
         m_err   <= (err_clear ? 3'b000 : m_err) | {sp, ab, ov};
         m_done  <= fin;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("cyc_start_check", int'(start_check), (m_stage < 0) ? 0 : (1 << m_stage));
         chk("cyc_in_progress", int'(check_in_progress), (m_stage < 0) ? 0 : 1);
         chk("cyc_pending", int'(pending), m_cnt);
         chk("cyc_check_done", int'(check_done), int'(m_done));
         chk("cyc_error", int'(error), int'(m_err));
      end
   end

   task automatic tick(input logic n, input logic d, input logic c, input logic r);
      need_check = n;
      adc_done   = d;
      err_clear  = c;
      reset      = r;
      @(posedge clk);
      #1;
      need_check = 1'b0;
      adc_done   = 1'b0;
      err_clear  = 1'b0;
      reset      = 1'b0;
   endtask

   initial begin
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      armed = 1'b1;
      chk("reset_start_check", int'(start_check), 0);
      chk("reset_pending", int'(pending), 0);
      chk("reset_error", int'(error), 0);
      chk("reset_in_progress", int'(check_in_progress), 0);

      // Single pass: need at edge 0, done at 3,5,7,9.
      tick(1, 0, 0, 0);
      chk("pass_e0_token", int'(start_check), 4'b0001);
      chk("pass_e0_pending", int'(pending), 1);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      tick(0, 1, 0, 0);
      chk("pass_e3_token", int'(start_check), 4'b0010);
      tick(0, 0, 0, 0); tick(0, 1, 0, 0);
      chk("pass_e5_token", int'(start_check), 4'b0100);
      tick(0, 0, 0, 0); tick(0, 1, 0, 0);
      chk("pass_e7_token", int'(start_check), 4'b1000);
      tick(0, 0, 0, 0); tick(0, 1, 0, 0);
      chk("pass_e9_token", int'(start_check), 4'b0000);
      chk("pass_e9_done", int'(check_done), 1);
      chk("pass_e9_pending", int'(pending), 0);
      tick(0, 0, 0, 0);
      chk("pass_done_one_cycle", int'(check_done), 0);

      // Queueing and overflow.
      tick(1, 0, 0, 0);
      chk("queue_p1", int'(pending), 1);
      tick(1, 0, 0, 0);
      chk("queue_p2", int'(pending), 2);
      tick(1, 0, 0, 0);
      chk("queue_p2_full", int'(pending), 2);
      chk("queue_overflow", int'(error), 3'b001);
      tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      chk("queue_reload_token", int'(start_check), 4'b0001);
      chk("queue_reload_pending", int'(pending), 1);
      chk("queue_reload_done", int'(check_done), 1);

      // Need on the completing edge with pending = 1.
      tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);
      chk("simul_pending", int'(pending), 1);
      chk("simul_token", int'(start_check), 4'b0001);
      chk("simul_done", int'(check_done), 1);

      // Full queue still rejects in a completion cycle.
      tick(0, 0, 1, 0);
      chk("clear_error", int'(error), 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);
      chk("full_simul_pending", int'(pending), 1);
      chk("full_simul_overflow", int'(error), 3'b001);
      tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
      chk("drain_pending", int'(pending), 0);
      tick(0, 0, 1, 0);

      // Timeout after TO cycles with no done.
      tick(1, 0, 0, 0);
      for (int i = 1; i < TO; i++) tick(0, 0, 0, 0);
      chk("to_before_token", int'(start_check), 4'b0001);
      chk("to_before_error", int'(error), 0);
      tick(0, 0, 0, 0);
      chk("to_error", int'(error), 3'b010);
      chk("to_token", int'(start_check), 0);
      chk("to_pending", int'(pending), 0);
      chk("to_no_done", int'(check_done), 0);

      // Spurious done and clear.
      tick(0, 0, 1, 0);
      tick(0, 1, 0, 0);
      chk("spur_error", int'(error), 3'b100);
      tick(0, 0, 1, 0);
      chk("spur_clear", int'(error), 0);
      tick(0, 1, 0, 0);
      tick(0, 1, 1, 0);
      chk("spur_set_wins", int'(error), 3'b100);
      tick(0, 0, 1, 0);

      // Reset mid-run.
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      chk("rst_pre_token", int'(start_check), 4'b0100);
      chk("rst_pre_pending", int'(pending), 2);
      tick(0, 0, 0, 1);
      chk("rst_token", int'(start_check), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_in_progress", int'(check_in_progress), 0);
      chk("rst_error", int'(error), 0);
      tick(0, 1, 0, 0);
      chk("rst_spurious", int'(error), 3'b100);
      chk("rst_stays_idle", int'(start_check), 0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
